hbotflaf_mse_monitor: RTL and testbench
=======================================

Name: hbotflaf_mse_monitor

Overview:
Downstream convergence monitor for the HBO-TFLAF adaptive filter. It consumes the registered error stream `error_d` from the filter top and squares each sample. It accumulates the squares over fixed windows of 2^LOG2_WIN valid samples and reports a windowed mean-squared error. A hysteresis FSM raises a converged flag after CONV_WINS consecutive windows below a programmable threshold.

Parameters:
- WIDTH, 16, error / MSE word width (signed error, unsigned MSE).
- QP, 12, fractional bits of error and MSE (fixed point Q(WIDTH-QP).QP).
- LOG2_WIN, 8, log2 of window length; 256 samples by default.
- WARMUP, 64, valid samples discarded after reset/restart (covers filter pipeline fill and initial transient).
- CONV_WINS, 4, consecutive below-threshold windows required to assert converged.

Ports:
- clk, input, 1, system clock, rising edge.
- reset, input, 1, asynchronous active-high reset.
- error_in, input, WIDTH, signed error sample (connect to error_d).
- sample_valid, input, 1, error_in qualifier; one sample per high cycle.
- restart, input, 1, synchronous restart; returns to WARMUP and clears statistics.
- threshold, input, WIDTH, unsigned MSE threshold, Q.QP; sampled at each window end.
- mse_out, output, WIDTH, unsigned windowed MSE, Q.QP, saturating.
- mse_valid, output, 1, one-cycle pulse when mse_out updates.
- converged, output, 1, convergence flag.
- win_count, output, 16, completed windows since restart; saturates at 0xFFFF.

Behaviour:
- Reset (async): all registers 0, FSM = WARMUP. Outputs reset to mse_out=0, mse_valid=0, converged=0, win_count=0.
- Stage S1, registered on a valid cycle:
  - sq = (error_in*error_in + 2^(QP-1)) >> QP.
  - Product is 2*WIDTH signed. sq is unsigned, 2*WIDTH-QP bits (20). Max sq = 0x40000 for error_in = -2^(WIDTH-1).
  - sq_valid follows sample_valid delayed one cycle.
- Stage S2:
  - Accumulator width is 2*WIDTH-QP+LOG2_WIN (28); it cannot overflow.
  - Sample counter is LOG2_WIN bits.
- FSM states:
  - WARMUP: count sq_valid beats. After WARMUP beats, go to ACCUM with acc=0 and cnt=0. Samples in WARMUP never enter acc.
  - ACCUM: on sq_valid, acc += sq and cnt++. When the beat with cnt = 2^LOG2_WIN-1 arrives, go to REPORT, latching final_acc = acc+sq.
  - REPORT (one cycle):
    - mse = (final_acc + 2^(LOG2_WIN-1)) >> LOG2_WIN, saturated to 2^WIDTH-1. Register it to mse_out and pulse mse_valid.
    - win_count++ (saturating).
    - acc and cnt clear, so the next window starts clean. Return to ACCUM.
    - A sq_valid beat arriving in the REPORT cycle is the first sample of the next window: acc = sq, cnt = 1. No sample is lost.
- Latency: mse_valid rises exactly 3 cycles after the sample_valid cycle carrying the window's last sample. Timing: S1, then S2/transition to REPORT, then registered outputs.
- Convergence counter:
  - below_cnt saturates at CONV_WINS. Updated in REPORT using the new mse and the current threshold.
  - If mse < threshold (strict): below_cnt++. Otherwise below_cnt = 0 and converged = 0 in the same cycle as mse_valid.
  - converged = 1 in the REPORT cycle where below_cnt reaches CONV_WINS. It stays high until a window fails or restart.
- restart:
  - Clears acc, cnt, below_cnt, win_count and converged, and enters WARMUP. Any in-flight S1 sample is discarded.
  - mse_out holds its last value.
  - restart has priority over sample_valid and over REPORT in the same cycle; no mse_valid pulse occurs that cycle.
- sample_valid low: all state holds; gaps of any length are allowed.
- threshold = 0: converged can never assert.

Decomposition:
- Shared header hbotflaf_defs.vh holds WIDTH/QP defaults and the FSM state encodings (WARMUP=2'd0, ACCUM=2'd1, REPORT=2'd2).
- One sub-module: sq_round (combinational signed square with round-half-up shift by QP). It is reused by the S1 register stage.

Test Plan:
1. Reset, then 64 samples of 0x7FFF followed by 256 samples of 0x0000 (WARMUP=64, LOG2_WIN=8) -> first mse_valid 3 cycles after last sample; mse_out=0x0000; win_count=1.
2. After warmup, 256 samples of 0x0400 -> mse_out=0x0100 (0.25^2 = 0.0625); same result with random 1-3 cycle sample_valid gaps.
3. After warmup, 256 samples of 0x8000 -> mse_out saturates to 0xFFFF; no accumulator wrap. Next window of 0x0400 gives 0x0100.
4. threshold=0x0010, error 0x0040 (sq=1) for 4 windows -> converged=1 coincident with 4th mse_valid. Then one window of 0x0400 -> converged=0 with that mse_valid.
5. Assert restart mid-window (sample 100), and separately in the REPORT cycle -> no mse_valid, converged=0, win_count=0. Next report comes only after 64 + 256 further valid samples.
6. Assert reset asynchronously between clock edges during ACCUM -> all outputs 0 immediately; FSM resumes in WARMUP after release.

Source files
------------

// File: rtl/hbotflaf_mse_monitor_pkg.sv
// Shared definitions for the HBO-TFLAF MSE convergence monitor:
// default word geometry and the monitor FSM state encoding.
package hbotflaf_mse_monitor_pkg;

    localparam int DEF_WIDTH    = 16;
    localparam int DEF_QP       = 12;
    localparam int DEF_LOG2_WIN = 8;

    typedef enum logic [1:0] {
        ST_WARMUP = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_REPORT = 2'd2
    } mon_state_t;

    // Width of a rounded square of a WIDTH-bit signed sample with QP fraction bits.
    function automatic int sq_width(input int width, input int qp);
        return 2 * width - qp;
    endfunction

endpackage

// File: rtl/hbotflaf_mse_monitor_sq_round.sv
// Combinational signed square, rounded half-up and shifted right by QP
// so the result stays in the same Q.QP scaling as the input.
module hbotflaf_mse_monitor_sq_round
    import hbotflaf_mse_monitor_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int QP    = DEF_QP
) (
    input  logic signed [WIDTH-1:0]          i_a,
    output logic        [2*WIDTH-QP-1:0]     o_sq
);

    localparam int SQW = sq_width(WIDTH, QP);
    localparam logic [2*WIDTH-1:0] HALF_LSB = {{(2*WIDTH-1){1'b0}}, 1'b1} << (QP - 1);

    logic signed [2*WIDTH-1:0] w_prod;
    logic        [2*WIDTH-1:0] w_sum;

    // A square is never negative, so the signed product can be added as unsigned.
    assign w_prod = i_a * i_a;
    assign w_sum  = $unsigned(w_prod) + HALF_LSB;
    assign o_sq   = SQW'(w_sum >> QP);

endmodule

// File: rtl/hbotflaf_mse_monitor.sv
// Windowed mean-squared-error monitor with hysteresis convergence flag.
// Squares the filter error, averages over 2^LOG2_WIN valid samples, reports MSE.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ST_WARMUP | discarding the first WARMUP valid samples after reset/restart
//   ST_ACCUM  | summing squares into the current window
//   ST_REPORT | one cycle: publish MSE, update convergence, start next window
module hbotflaf_mse_monitor
    import hbotflaf_mse_monitor_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int QP        = DEF_QP,
    parameter int LOG2_WIN  = DEF_LOG2_WIN,
    parameter int WARMUP    = 64,
    parameter int CONV_WINS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [WIDTH-1:0] error_in,
    input  logic                    sample_valid,
    input  logic                    restart,
    input  logic        [WIDTH-1:0] threshold,
    output logic        [WIDTH-1:0] mse_out,
    output logic                    mse_valid,
    output logic                    converged,
    output logic        [15:0]      win_count
);

    localparam int SQW  = sq_width(WIDTH, QP);
    localparam int ACCW = SQW + LOG2_WIN;
    localparam int WCW  = $clog2(WARMUP + 1);
    localparam int BCW  = $clog2(CONV_WINS + 1);
    localparam logic [ACCW-1:0]  HALF_WIN = {{(ACCW-1){1'b0}}, 1'b1} << (LOG2_WIN - 1);
    localparam logic [WIDTH-1:0] MSE_MAX  = '1;

    logic [SQW-1:0]      w_sq;
    logic [SQW-1:0]      r_sq;
    logic                r_sq_valid;

    mon_state_t          r_state, w_nxt_state;
    logic [ACCW-1:0]     r_acc, w_nxt_acc;
    logic [LOG2_WIN-1:0] r_cnt, w_nxt_cnt;
    logic [ACCW-1:0]     r_final_acc, w_nxt_final_acc;
    logic [WCW-1:0]      r_warm, w_nxt_warm;
    logic [BCW-1:0]      r_below, w_nxt_below;
    logic [WIDTH-1:0]    r_mse_out, w_nxt_mse_out;
    logic                r_mse_valid, w_nxt_mse_valid;
    logic                r_conv, w_nxt_conv;
    logic [15:0]         r_win, w_nxt_win;

    logic [ACCW-1:0]     w_acc_sum;
    logic [ACCW-1:0]     w_round_sum;
    logic [SQW-1:0]      w_mse_raw;
    logic [WIDTH-1:0]    w_mse_sat;
    logic [BCW-1:0]      w_below_inc;

    hbotflaf_mse_monitor_sq_round #(
        .WIDTH (WIDTH),
        .QP    (QP)
    ) u_sq_round (
        .i_a  (error_in),
        .o_sq (w_sq)
    );

    // S1: square register; restart drops whatever sample is in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sq       <= '0;
            r_sq_valid <= 1'b0;
        end else if (restart) begin
            r_sq_valid <= 1'b0;
        end else begin
            r_sq_valid <= sample_valid;
            if (sample_valid) begin
                r_sq <= w_sq;
            end
        end
    end

    assign w_acc_sum   = r_acc + ACCW'(r_sq);
    assign w_round_sum = r_final_acc + HALF_WIN;
    assign w_mse_raw   = SQW'(w_round_sum >> LOG2_WIN);
    assign w_mse_sat   = (w_mse_raw > SQW'(MSE_MAX)) ? MSE_MAX : w_mse_raw[WIDTH-1:0];
    assign w_below_inc = (r_below == BCW'(CONV_WINS)) ? r_below : r_below + 1'b1;

    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_acc       = r_acc;
        w_nxt_cnt       = r_cnt;
        w_nxt_final_acc = r_final_acc;
        w_nxt_warm      = r_warm;
        w_nxt_below     = r_below;
        w_nxt_mse_out   = r_mse_out;
        w_nxt_mse_valid = 1'b0;
        w_nxt_conv      = r_conv;
        w_nxt_win       = r_win;

        case (r_state)
            ST_WARMUP: begin
                if (r_sq_valid) begin
                    if (r_warm == WCW'(WARMUP - 1)) begin
                        w_nxt_state = ST_ACCUM;
                        w_nxt_acc   = '0;
                        w_nxt_cnt   = '0;
                    end else begin
                        w_nxt_warm = r_warm + 1'b1;
                    end
                end
            end
            ST_ACCUM: begin
                if (r_sq_valid) begin
                    if (r_cnt == '1) begin
                        w_nxt_state     = ST_REPORT;
                        w_nxt_final_acc = w_acc_sum;
                        w_nxt_acc       = '0;
                        w_nxt_cnt       = '0;
                    end else begin
                        w_nxt_acc = w_acc_sum;
                        w_nxt_cnt = r_cnt + 1'b1;
                    end
                end
            end
            ST_REPORT: begin
                w_nxt_state     = ST_ACCUM;
                w_nxt_mse_out   = w_mse_sat;
                w_nxt_mse_valid = 1'b1;
                w_nxt_win       = (r_win == 16'hFFFF) ? r_win : r_win + 16'd1;
                if (w_mse_sat < threshold) begin
                    w_nxt_below = w_below_inc;
                    w_nxt_conv  = r_conv | (w_below_inc == BCW'(CONV_WINS));
                end else begin
                    w_nxt_below = '0;
                    w_nxt_conv  = 1'b0;
                end
                // A beat landing here opens the next window rather than being lost.
                if (r_sq_valid) begin
                    w_nxt_acc = ACCW'(r_sq);
                    w_nxt_cnt = {{(LOG2_WIN-1){1'b0}}, 1'b1};
                end else begin
                    w_nxt_acc = '0;
                    w_nxt_cnt = '0;
                end
            end
            default: begin
                w_nxt_state = ST_WARMUP;
            end
        endcase

        if (restart) begin
            w_nxt_state     = ST_WARMUP;
            w_nxt_acc       = '0;
            w_nxt_cnt       = '0;
            w_nxt_warm      = '0;
            w_nxt_below     = '0;
            w_nxt_conv      = 1'b0;
            w_nxt_win       = '0;
            w_nxt_mse_valid = 1'b0;
            w_nxt_mse_out   = r_mse_out;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_WARMUP;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_final_acc <= '0;
            r_warm      <= '0;
            r_below     <= '0;
            r_mse_out   <= '0;
            r_mse_valid <= 1'b0;
            r_conv      <= 1'b0;
            r_win       <= '0;
        end else begin
            r_state     <= w_nxt_state;
            r_acc       <= w_nxt_acc;
            r_cnt       <= w_nxt_cnt;
            r_final_acc <= w_nxt_final_acc;
            r_warm      <= w_nxt_warm;
            r_below     <= w_nxt_below;
            r_mse_out   <= w_nxt_mse_out;
            r_mse_valid <= w_nxt_mse_valid;
            r_conv      <= w_nxt_conv;
            r_win       <= w_nxt_win;
        end
    end

    assign mse_out   = r_mse_out;
    assign mse_valid = r_mse_valid;
    assign converged = r_conv;
    assign win_count = r_win;

endmodule

// File: tb/tb_hbotflaf_mse_monitor.sv
// Scoreboard bench for hbotflaf_mse_monitor: a windowed-average model predicts
// each report; a negedge monitor pops and compares whenever mse_valid pulses.
module tb_hbotflaf_mse_monitor;

    localparam int WARM  = 64;
    localparam int WIN   = 256;
    localparam int CONVW = 4;

    logic               clk;
    logic               reset;
    logic signed [15:0] error_in;
    logic               sample_valid;
    logic               restart;
    logic        [15:0] threshold;
    logic        [15:0] mse_out;
    logic               mse_valid;
    logic               converged;
    logic        [15:0] win_count;

    hbotflaf_mse_monitor #(
        .WIDTH(16), .QP(12), .LOG2_WIN(8), .WARMUP(WARM), .CONV_WINS(CONVW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .error_in     (error_in),
        .sample_valid (sample_valid),
        .restart      (restart),
        .threshold    (threshold),
        .mse_out      (mse_out),
        .mse_valid    (mse_valid),
        .converged    (converged),
        .win_count    (win_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    typedef struct {
        int mse;
        bit conv;
        int wins;
        int due;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   last_mse = 0;

    // Model state: what has been observed since the last restart/reset.
    int     m_warm, m_n, m_below, m_wins;
    longint m_sum;
    bit     m_conv;

    task automatic chk(input string name, input longint act, input longint exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic model_clear();
        m_warm  = 0;
        m_n     = 0;
        m_sum   = 0;
        m_below = 0;
        m_wins  = 0;
        m_conv  = 0;
    endtask

    // k is the index of the clock edge that captures this sample.
    task automatic model_sample(input logic signed [15:0] e, input int k);
        longint p, sq, mse;
        exp_t   x;
        if (m_warm < WARM) begin
            m_warm++;
            return;
        end
        p     = longint'(e) * longint'(e);
        sq    = (p + 2048) / 4096;
        m_sum = m_sum + sq;
        m_n++;
        if (m_n == WIN) begin
            mse = (m_sum + WIN / 2) / WIN;
            if (mse > 65535) mse = 65535;
            if (m_wins < 65535) m_wins++;
            if (mse < longint'(threshold)) begin
                if (m_below < CONVW) m_below++;
                if (m_below == CONVW) m_conv = 1;
            end else begin
                m_below = 0;
                m_conv  = 0;
            end
            x.mse  = int'(mse);
            x.conv = m_conv;
            x.wins = m_wins;
            x.due  = k + 2;
            q.push_back(x);
            m_sum = 0;
            m_n   = 0;
        end
    endtask

    // Restart captured at edge r cancels every report not yet visible by then.
    task automatic model_restart(input int r);
        while (q.size() > 0 && q[q.size()-1].due >= r) void'(q.pop_back());
        model_clear();
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            while (q.size() > 0 && q[0].due < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL missing_mse_valid: no pulse at cycle %0d, expected mse 0x%0h", q[0].due, q[0].mse);
                void'(q.pop_front());
            end
            if (mse_valid === 1'b1) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_mse_valid: pulse with mse 0x%0h at cycle %0d, expected none", mse_out, cyc);
                end else begin
                    mon_e = q.pop_front();
                    chk("mse_out", longint'(mse_out), longint'(mon_e.mse));
                    chk("converged", longint'(converged), longint'(mon_e.conv));
                    chk("win_count", longint'(win_count), longint'(mon_e.wins));
                    chk("latency", longint'(cyc), longint'(mon_e.due));
                    last_mse = mon_e.mse;
                end
            end
        end
    end

    task automatic idle();
        sample_valid = 1'b0;
        restart      = 1'b0;
        @(negedge clk);
    endtask

    task automatic send(input logic signed [15:0] e);
        sample_valid = 1'b1;
        restart      = 1'b0;
        error_in     = e;
        model_sample(e, cyc + 1);
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic send_block(input logic signed [15:0] e, input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            send(e);
            if (gaps) repeat ($urandom_range(1, 3)) idle();
        end
    endtask

    task automatic send_random(input int n, input int max_gap);
        logic signed [15:0] e;
        for (int i = 0; i < n; i++) begin
            e = 16'($signed($urandom_range(0, 1023)) - 512);
            send(e);
            repeat ($urandom_range(0, max_gap)) idle();
        end
    endtask

    task automatic do_restart(input bit with_sample);
        restart      = 1'b1;
        sample_valid = with_sample;
        error_in     = 16'sh1234;
        model_restart(cyc + 1);
        @(negedge clk);
        restart      = 1'b0;
        sample_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() > 0; i++) idle();
        repeat (2) idle();
        chk("drain_pending", longint'(q.size()), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        sample_valid = 1'b0;
        restart      = 1'b0;
        error_in     = '0;
        threshold    = '0;
        model_clear();
        repeat (3) @(negedge clk);
        chk("reset_mse_out", longint'(mse_out), 0);
        chk("reset_mse_valid", longint'(mse_valid), 0);
        chk("reset_converged", longint'(converged), 0);
        chk("reset_win_count", longint'(win_count), 0);
        reset = 1'b0;

        // Warmup samples are discarded even when large.
        send_block(16'sh7FFF, WARM, 1'b0);
        send_block(16'sh0000, WIN, 1'b0);
        drain();
        chk("t1_mse", longint'(last_mse), 0);
        chk("t1_win", longint'(win_count), 1);

        send_block(16'sh0400, WIN, 1'b0);
        drain();
        chk("t2_mse", longint'(last_mse), 16'h0100);
        send_block(16'sh0400, WIN, 1'b1);
        drain();
        chk("t2_gap_mse", longint'(last_mse), 16'h0100);

        send_block(-16'sh8000, WIN, 1'b0);
        drain();
        chk("t3_sat_mse", longint'(last_mse), 16'hFFFF);
        send_block(16'sh0400, WIN, 1'b0);
        drain();
        chk("t3_after_sat", longint'(last_mse), 16'h0100);

        threshold = 16'h0010;
        for (int w = 0; w < CONVW; w++) send_block(16'sh0040, WIN, 1'b0);
        drain();
        chk("t4_converged", longint'(converged), 1);
        send_block(16'sh0400, WIN, 1'b0);
        drain();
        chk("t4_deconverged", longint'(converged), 0);
        threshold = 16'h0000;

        // Restart mid-window, with a sample offered in the restart cycle.
        send_random(100, 0);
        do_restart(1'b1);
        repeat (3) idle();
        drain();
        chk("t5_mid_conv", longint'(converged), 0);
        chk("t5_mid_win", longint'(win_count), 0);
        chk("t5_mid_hold", longint'(mse_out), longint'(last_mse));
        send_random(WARM + WIN, 2);
        drain();
        chk("t5_after_mid_win", longint'(win_count), 1);

        // Restart exactly in the REPORT cycle.
        send_random(WARM + WIN, 0);
        idle();
        do_restart(1'b0);
        repeat (4) idle();
        drain();
        chk("t5_report_win", longint'(win_count), 0);
        send_random(WARM + WIN, 0);
        drain();
        chk("t5_after_report_win", longint'(win_count), 1);

        threshold = 16'($urandom_range(8, 48));
        send_random(6 * WIN, 2);
        drain();
        threshold = 16'h0040;
        send_random(5 * WIN, 1);
        drain();
        chk("t6_converged", longint'(converged), 1);

        // Asynchronous reset between clock edges during ACCUM.
        send_random(50, 0);
        sample_valid = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("t7_mse_out", longint'(mse_out), 0);
        chk("t7_mse_valid", longint'(mse_valid), 0);
        chk("t7_converged", longint'(converged), 0);
        chk("t7_win_count", longint'(win_count), 0);
        q.delete();
        model_clear();
        last_mse = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        send_random(WARM + WIN, 1);
        drain();
        chk("t7_resume_win", longint'(win_count), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
